lsu_smem_responder: RTL

- Multi-lane scratchpad responder that terminates the per-lane D-cache request/response protocol issued by the load/store unit.
- Accepts per-lane read/write requests, resolves bank conflicts among lanes, and performs byte-enabled writes and reads on banked single-port SRAM.
- Returns one grouped response per accepted read group, carrying a lane mask and the request tag.
- Sits on the shared-memory address path, behind the LSU address-type split.

---
 rtl/lsu_smem_pkg.sv | 33 +++
 rtl/lsu_smem_bank.sv | 29 ++
 rtl/lsu_smem_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lsu_smem_pkg.sv
// Shared widths, request record and address-decode helpers for the scratchpad responder.
// Bank index is the low word-address bits, row the next bits; upper bits alias.
package lsu_smem_pkg;

   localparam int SMEM_NUM_LANES  = 4;
   localparam int SMEM_NUM_BANKS  = 4;
   localparam int SMEM_BANK_WORDS = 256;
   localparam int SMEM_ADDR_WIDTH = 30;
   localparam int SMEM_TAG_WIDTH  = 10;

   localparam int BANK_BITS = $clog2(SMEM_NUM_BANKS);
   localparam int ROW_BITS  = $clog2(SMEM_BANK_WORDS);

   typedef logic [BANK_BITS-1:0] bank_idx_t;
   typedef logic [ROW_BITS-1:0]  row_idx_t;

   typedef struct packed {
      logic                      rw;
      logic [SMEM_ADDR_WIDTH-1:0] addr;
      logic [3:0]                byteen;
      logic [31:0]               data;
      logic [SMEM_TAG_WIDTH-1:0] tag;
   } lane_req_t;

   function automatic bank_idx_t bank_sel(input logic [SMEM_ADDR_WIDTH-1:0] addr);
      return addr[BANK_BITS-1:0];
   endfunction

   function automatic row_idx_t row_sel(input logic [SMEM_ADDR_WIDTH-1:0] addr);
      return addr[BANK_BITS +: ROW_BITS];
   endfunction

endpackage

// File: rtl/lsu_smem_bank.sv
// Single-port 32-bit SRAM bank with byte-enabled write and a one-cycle registered read.
// The read register only loads on a read enable, so it holds across stalls and writes.
module lsu_smem_bank #(
   parameter int WORDS = 256
) (
   input  logic                     clk,
   input  logic                     en_i,
   input  logic                     we_i,
   input  logic [$clog2(WORDS)-1:0] row_i,
   input  logic [3:0]               byteen_i,
   input  logic [31:0]              wdata_i,
   output logic [31:0]              rdata_o
);

   logic [31:0] mem_q [WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         for (int k = 0; k < 4; k++) begin
            if (byteen_i[k]) mem_q[row_i][8*k +: 8] <= wdata_i[8*k +: 8];
         end
      end
      if (en_i && !we_i) rdata_q <= mem_q[row_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_smem_responder.sv
// Multi-lane banked scratchpad: grants a conflict-free same-rw/same-tag lane group per cycle.
// Writes commit at the grant edge; reads answer one cycle later and stall while the response is held.
module lsu_smem_responder
   import lsu_smem_pkg::*;
#(
   parameter int NUM_LANES  = SMEM_NUM_LANES,
   parameter int NUM_BANKS  = SMEM_NUM_BANKS,
   parameter int BANK_WORDS = SMEM_BANK_WORDS,
   parameter int ADDR_WIDTH = SMEM_ADDR_WIDTH,
   parameter int TAG_WIDTH  = SMEM_TAG_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_LANES-1:0]          req_valid_i,
   input  logic [NUM_LANES-1:0]          req_rw_i,
   input  logic [NUM_LANES*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_LANES*4-1:0]        req_byteen_i,
   input  logic [NUM_LANES*32-1:0]       req_data_i,
   input  logic [NUM_LANES*TAG_WIDTH-1:0] req_tag_i,
   output logic [NUM_LANES-1:0]          req_ready_o,
   output logic                          rsp_valid_o,
   output logic [NUM_LANES-1:0]          rsp_tmask_o,
   output logic [NUM_LANES*32-1:0]       rsp_data_o,
   output logic [TAG_WIDTH-1:0]          rsp_tag_o,
   input  logic                          rsp_ready_i
);

   lane_req_t                req       [NUM_LANES];
   bank_idx_t                lane_bank [NUM_LANES];
   row_idx_t                 lane_row  [NUM_LANES];
   logic                     unused_addr_bits;

   logic [NUM_LANES-1:0]     grant;
   logic                     lead_rw;
   logic [TAG_WIDTH-1:0]     lead_tag;
   logic                     slot_free;
   logic                     rd_fire;

   logic [NUM_BANKS-1:0]     bk_en;
   logic [NUM_BANKS-1:0]     bk_we;
   row_idx_t                 bk_row    [NUM_BANKS];
   logic [3:0]               bk_be     [NUM_BANKS];
   logic [31:0]              bk_wdata  [NUM_BANKS];
   logic [31:0]              bk_rdata  [NUM_BANKS];

   logic                     rsp_valid_q, rsp_valid_d;
   logic [NUM_LANES-1:0]     rsp_tmask_q, rsp_tmask_d;
   logic [TAG_WIDTH-1:0]     rsp_tag_q,   rsp_tag_d;
   bank_idx_t                rsp_bank_q  [NUM_LANES];
   bank_idx_t                rsp_bank_d  [NUM_LANES];

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         req[i].rw     = req_rw_i[i];
         req[i].addr   = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
         req[i].byteen = req_byteen_i[i*4 +: 4];
         req[i].data   = req_data_i[i*32 +: 32];
         req[i].tag    = req_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
         lane_bank[i]  = bank_sel(req[i].addr);
         lane_row[i]   = row_sel(req[i].addr);
      end
   end

   // Address bits above bank+row alias onto the same word.
   always_comb begin
      unused_addr_bits = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         unused_addr_bits = unused_addr_bits ^ (^req[i].addr[SMEM_ADDR_WIDTH-1:BANK_BITS+ROW_BITS]);
      end
   end

   assign slot_free = !rsp_valid_q || rsp_ready_i;

   always_comb begin
      logic                 found;
      logic [NUM_BANKS-1:0] used;
      found    = 1'b0;
      used     = '0;
      lead_rw  = 1'b0;
      lead_tag = '0;
      grant    = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (req_valid_i[i] && !found) begin
            found    = 1'b1;
            lead_rw  = req[i].rw;
            lead_tag = req[i].tag;
         end
      end
      // Ascending scan: the lowest lane wins each bank, duplicates serialise.
      for (int i = 0; i < NUM_LANES; i++) begin
         if (!reset && req_valid_i[i] && (req[i].rw == lead_rw) && (req[i].tag == lead_tag) &&
             !used[lane_bank[i]] && (req[i].rw || slot_free)) begin
            grant[i]            = 1'b1;
            used[lane_bank[i]]  = 1'b1;
         end
      end
   end

   assign req_ready_o = grant;
   assign rd_fire     = (|grant) && !lead_rw;

   always_comb begin
      bk_en = '0;
      bk_we = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bk_row[b]   = '0;
         bk_be[b]    = '0;
         bk_wdata[b] = '0;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
         if (grant[i]) begin
            bk_en[lane_bank[i]]    = 1'b1;
            bk_we[lane_bank[i]]    = req[i].rw;
            bk_row[lane_bank[i]]   = lane_row[i];
            bk_be[lane_bank[i]]    = req[i].byteen;
            bk_wdata[lane_bank[i]] = req[i].data;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      lsu_smem_bank #(
         .WORDS    (BANK_WORDS)
      ) u_bank (
         .clk      (clk),
         .en_i     (bk_en[b]),
         .we_i     (bk_we[b]),
         .row_i    (bk_row[b]),
         .byteen_i (bk_be[b]),
         .wdata_i  (bk_wdata[b]),
         .rdata_o  (bk_rdata[b])
      );
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_tmask_d = rsp_tmask_q;
      rsp_tag_d   = rsp_tag_q;
      for (int i = 0; i < NUM_LANES; i++) rsp_bank_d[i] = rsp_bank_q[i];
      if (rd_fire) begin
         rsp_valid_d = 1'b1;
         rsp_tmask_d = grant;
         rsp_tag_d   = lead_tag;
         for (int i = 0; i < NUM_LANES; i++) rsp_bank_d[i] = lane_bank[i];
      end else if (rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_tmask_q <= '0;
         rsp_tag_q   <= '0;
         for (int i = 0; i < NUM_LANES; i++) rsp_bank_q[i] <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_tmask_q <= rsp_tmask_d;
         rsp_tag_q   <= rsp_tag_d;
         for (int i = 0; i < NUM_LANES; i++) rsp_bank_q[i] <= rsp_bank_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) rsp_data_o[i*32 +: 32] = bk_rdata[rsp_bank_q[i]];
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_tmask_o = rsp_tmask_q;
   assign rsp_tag_o   = rsp_tag_q;

endmodule
